serial_half_subtractor: RTL

Bit-serial subtractor computing a - b one bit per clock, LSB first, using half-subtractor logic with a registered borrow. It is the inverse-direction counterpart to the team's half adder: a difference/borrow unit in place of a sum/carry unit. A start/busy/done handshake makes it usable as a small sequential arithmetic engine in the datapath. Results are held stable until the next accepted start.

---
 rtl/serial_half_subtractor.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_half_subtractor.sv
// serial_half_subtractor: bit-serial a - b, LSB first, with a registered borrow.
// Handshake: start (in IDLE/DONE) -> busy for W cycles -> done pulse for one cycle.
// Ports: clk, rst (sync, active-high), start, a[W], b[W] -> busy, done, diff[W], borrow
//        (+ ovf when SERIAL_SUB_OVF_EN is defined: signed overflow of a - b).
// Optional feature macro: SERIAL_SUB_OVF_EN
module serial_half_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic         borrow,
    output logic         ovf
`else
    output logic         borrow
`endif
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    // Holds the upper W-1 bits of the partial result; bit 0 of the
    // full shift register would be shifted out unused, so it is not kept.
    logic [W-2:0]  res;
    logic          borrow_r;
    logic [CW-1:0] cnt;

    logic          x;
    logic          y;
    logic          d;
    logic          bnext;
    logic          last;
    logic          accept;
    logic [W-1:0]  res_nx;

`ifdef SERIAL_SUB_OVF_EN
    logic          a_msb;
    logic          b_msb;
`endif

    // Half-subtractor bit slice with borrow-in
    assign x      = opa[0];
    assign y      = opb[0];
    assign d      = x ^ y ^ borrow_r;
    assign bnext  = (~x & y) | (~(x ^ y) & borrow_r);
    assign res_nx = {d, res};
    assign last   = (cnt == CW'(W - 1));
    assign accept = start && ((state == IDLE) || (state == DONE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? SHIFT : IDLE;
            SHIFT:   state_nx = last ? DONE : SHIFT;
            DONE:    state_nx = start ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE:    ;
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            borrow_r <= 1'b0;
            cnt      <= '0;
            diff     <= '0;
            borrow   <= 1'b0;
        end else if (accept) begin
            opa      <= a;
            opb      <= b;
            res      <= '0;
            borrow_r <= 1'b0;
            cnt      <= '0;
        end else if (state == SHIFT) begin
            opa      <= opa >> 1;
            opb      <= opb >> 1;
            res      <= res_nx[W-1:1];
            borrow_r <= bnext;
            cnt      <= cnt + 1'b1;
            if (last) begin
                diff   <= res_nx;
                borrow <= bnext;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept because opa/opb are consumed by shifting.
    // On the final edge d is the result MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= a[W-1];
            b_msb <= b[W-1];
        end else if (state == SHIFT && last) begin
            ovf <= (a_msb != b_msb) && (d != a_msb);
        end
    end
`endif

endmodule
